// File: rtl/fw_pkg.sv
// Shared types and defaults for the Floyd-Warshall control sequencer.
// The BARRIER encoding only exists when FW_K_BARRIER_EN is defined.
package fw_pkg;

    localparam int FW_N_DEF        = 8;
    localparam int FW_IDX_W_DEF    = 3;
    localparam int FW_PIPE_LAT_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
`ifdef FW_K_BARRIER_EN
        ST_BARRIER = 3'd2,
`endif
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } fw_seq_state_t;

    // Ceiling log2, usable in constant expressions for counter widths.
    function automatic int fw_clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fw_idx_counter.sv
// Three-level nested (k, i, j) loop counter, j innermost; exposes both the
// registered indices and their next values so callers can register derived flags.
module fw_idx_counter
#(
    parameter int N     = 8,
    parameter int IDX_W = 3
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] k,
    output logic [IDX_W-1:0] i,
    output logic [IDX_W-1:0] j,
    output logic [IDX_W-1:0] k_nxt,
    output logic [IDX_W-1:0] i_nxt,
    output logic [IDX_W-1:0] j_nxt,
    output logic             plane_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [IDX_W-1:0] k_q, k_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q <= '0;
            i_q <= '0;
            j_q <= '0;
        end else begin
            k_q <= k_d;
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    // Wraps are explicit compares against N-1 so non-power-of-two N works.
    always_comb begin
        k_d = k_q;
        i_d = i_q;
        j_d = j_q;
        if (clr) begin
            k_d = '0;
            i_d = '0;
            j_d = '0;
        end else if (en) begin
            if (j_q == LAST_IDX) begin
                j_d = '0;
                if (i_q == LAST_IDX) begin
                    i_d = '0;
                    k_d = (k_q == LAST_IDX) ? '0 : k_q + 1'b1;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end else begin
                j_d = j_q + 1'b1;
            end
        end
    end

    assign k          = k_q;
    assign i          = i_q;
    assign j          = j_q;
    assign k_nxt      = k_d;
    assign i_nxt      = i_d;
    assign j_nxt      = j_d;
    assign plane_last = (i_q == LAST_IDX) && (j_q == LAST_IDX);

endmodule

// File: rtl/fw_sequencer.sv
// Floyd-Warshall loop sequencer: issues N^3 (k,i,j) triples, drains the datapath,
// then pulses done. Define FW_K_BARRIER_EN to insert a drain-length gap between k planes.
module fw_sequencer
    import fw_pkg::*;
#(
    parameter int N        = FW_N_DEF,
    parameter int IDX_W    = FW_IDX_W_DEF,
    parameter int PIPE_LAT = FW_PIPE_LAT_DEF
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [IDX_W-1:0] k,
    output logic [IDX_W-1:0] i,
    output logic [IDX_W-1:0] j,
    output logic             row_is_k,
    output logic             col_is_k
);

    localparam int               CNT_W    = fw_clog2(PIPE_LAT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PIPE_LAT - 1);

    fw_seq_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic             row_is_k_q, row_is_k_d;
    logic             col_is_k_q, col_is_k_d;

    logic             idx_clr;
    logic             idx_en;
    logic             plane_last;
    logic             last_triple;
    logic [IDX_W-1:0] k_nxt, i_nxt, j_nxt;

    fw_idx_counter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk        (clk),
        .reset      (reset),
        .clr        (idx_clr),
        .en         (idx_en),
        .k          (k),
        .i          (i),
        .j          (j),
        .k_nxt      (k_nxt),
        .i_nxt      (i_nxt),
        .j_nxt      (j_nxt),
        .plane_last (plane_last)
    );

    assign last_triple = plane_last && (k == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            row_is_k_q <= 1'b0;
            col_is_k_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            row_is_k_q <= row_is_k_d;
            col_is_k_q <= col_is_k_d;
        end
    end

    // The displayed triple only moves on once it has actually been issued
    // (valid_q), which is what makes a stalled triple reappear untouched.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (valid_q) begin
                    if (last_triple) begin
                        state_d = ST_DRAIN;
                        cnt_d   = CNT_LOAD;
                    end
`ifdef FW_K_BARRIER_EN
                    else if (plane_last) begin
                        state_d = ST_BARRIER;
                        cnt_d   = CNT_LOAD;
                    end
`endif
                end
            end
`ifdef FW_K_BARRIER_EN
            ST_BARRIER: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        idx_en     = (state_q == ST_RUN) && valid_q;
`ifdef FW_K_BARRIER_EN
        idx_clr    = !((state_d == ST_RUN) || (state_d == ST_BARRIER));
        busy_d     = (state_d == ST_RUN) || (state_d == ST_BARRIER) || (state_d == ST_DRAIN);
`else
        idx_clr    = (state_d != ST_RUN);
        busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
`endif
        done_d     = (state_d == ST_DONE);
        valid_d    = (state_d == ST_RUN) && !stall;
        row_is_k_d = valid_d && (i_nxt == k_nxt);
        col_is_k_d = valid_d && (j_nxt == k_nxt);
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign valid    = valid_q;
    assign row_is_k = row_is_k_q;
    assign col_is_k = col_is_k_q;

endmodule

// File: tb/tb_fw_sequencer.sv
// Directed bench for fw_sequencer at N=4, PIPE_LAT=3; cycle c is the clock period
// following edge c-1, with the start pulse sampled at edge 0.
module tb_fw_sequencer;
    import fw_pkg::*;

    localparam int N     = 4;
    localparam int IDX_W = 2;
    localparam int PL    = 3;
    localparam int NTRIP = N * N * N;
`ifdef FW_K_BARRIER_EN
    localparam int BAR = 1;
`else
    localparam int BAR = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic busy, done, valid, row_is_k, col_is_k;
    logic [IDX_W-1:0] k, i, j;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    fw_sequencer #(
        .N        (N),
        .IDX_W    (IDX_W),
        .PIPE_LAT (PL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .valid    (valid),
        .k        (k),
        .i        (i),
        .j        (j),
        .row_is_k (row_is_k),
        .col_is_k (col_is_k)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Cycle in which triple t is issued: one per cycle from cycle 1, shifted by
    // the 3-cycle stall window before triple 9 and by 3-cycle plane barriers.
    function automatic int issue_cyc(input int t, input bit st);
        int c;
        c = t + 1;
        if (st && t >= 9) c = c + 3;
        if (BAR != 0) c = c + PL * (t / (N * N));
        return c;
    endfunction

    // One full run; st applies the stall window, extra adds ignored start pulses.
    task automatic run_one(input string tag, input bit st, input bit extra);
        int t, nv, nr, nc, nb, done_c, ek, ei, ej;
        bit exp_v;
        t = 0; nv = 0; nr = 0; nc = 0; nb = 0;
        done_c = issue_cyc(NTRIP - 1, st) + PL + 1;
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        forever begin
            exp_v = (t < NTRIP) && (cyc == issue_cyc(t, st));
            ek = t / (N * N);
            ei = (t / N) % N;
            ej = t % N;
            check({tag, ".valid"}, 32'(valid), 32'(exp_v));
            check({tag, ".busy"}, 32'(busy), 32'(cyc < done_c));
            check({tag, ".done"}, 32'(done), 32'(cyc == done_c));
            if (exp_v) begin
                check({tag, ".k"}, 32'(k), 32'(ek));
                check({tag, ".i"}, 32'(i), 32'(ei));
                check({tag, ".j"}, 32'(j), 32'(ej));
                check({tag, ".row_is_k"}, 32'(row_is_k), 32'(ei == ek));
                check({tag, ".col_is_k"}, 32'(col_is_k), 32'(ej == ek));
                nv++;
                if (row_is_k) nr++;
                if (col_is_k) nc++;
                if (row_is_k && col_is_k) nb++;
                t++;
            end else begin
                check({tag, ".row_is_k_idle"}, 32'(row_is_k), 32'd0);
                check({tag, ".col_is_k_idle"}, 32'(col_is_k), 32'd0);
                if (t >= NTRIP) begin
                    check({tag, ".idx_zero"}, {26'd0, k, i, j}, 32'd0);
                end else if (st && cyc >= 10 && cyc <= 12) begin
                    check({tag, ".held_triple"}, {26'd0, k, i, j}, 32'(ek * 16 + ei * 4 + ej));
                end
            end
            if (cyc == done_c + 1) break;
            stall = st && (cyc + 1 >= 10) && (cyc + 1 <= 12);
            start = extra && (cyc == 5 || cyc == 66 || cyc == 67 || cyc == 68);
            tick();
        end
        stall = 1'b0;
        start = 1'b0;
        check({tag, ".valid_count"}, 32'(nv), 32'(NTRIP));
        check({tag, ".row_count"}, 32'(nr), 32'd16);
        check({tag, ".col_count"}, 32'(nc), 32'd16);
        check({tag, ".both_count"}, 32'(nb), 32'd4);
        check({tag, ".done_cycle"}, 32'(done_c), 32'(BAR != 0 ? 77 + (st ? 3 : 0) : 68 + (st ? 3 : 0)));
    endtask

    initial begin
        int nd, nbusy;

        // Reset state
        repeat (3) tick();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.valid", 32'(valid), 32'd0);
        check("rst.k", 32'(k), 32'd0);
        check("rst.i", 32'(i), 32'd0);
        check("rst.j", 32'(j), 32'd0);
        check("rst.row_is_k", 32'(row_is_k), 32'd0);
        check("rst.col_is_k", 32'(col_is_k), 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        check("idle.busy", 32'(busy), 32'd0);

        run_one("basic", 1'b0, 1'b0);
        repeat (2) tick();
        run_one("stall", 1'b1, 1'b0);
        repeat (2) tick();
        // Chained: the second run's start is sampled in the IDLE cycle after done.
        run_one("busy_start", 1'b0, 1'b1);
        run_one("restart", 1'b0, 1'b0);
        repeat (2) tick();

        // Reset mid-run, sampled at edge 30.
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        while (cyc < 30) tick();
        check("abort.pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.valid", 32'(valid), 32'd0);
        check("abort.kij", {26'd0, k, i, j}, 32'd0);
        check("abort.flags", {30'd0, row_is_k, col_is_k}, 32'd0);
        check("abort.state", 32'(dut.state_q), 32'(ST_IDLE));
        nd = 0;
        nbusy = 0;
        repeat (80) begin
            if (done) nd++;
            if (busy) nbusy++;
            tick();
        end
        check("abort.no_done", 32'(nd), 32'd0);
        check("abort.no_busy", 32'(nbusy), 32'd0);
        run_one("after_abort", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
